// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch unit
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR              = 32'h00000013;
   localparam int          DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - counts consecutive stalled fetch cycles and flags the limit
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog
   import fetch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic nRST,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_count;

   // expired fires during the stalled cycle that completes the limit
   assign expired = count_en && (r_count == LAST_COUNT);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (count_en && !expired) begin
         r_count <= r_count + 8'd1;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch FSM with sticky fault flag
// Define FETCH_TIMEOUT_EN to add a watchdog on continuous mem_busy.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic [31:0] PCaddr,
   input  logic        fetch_en,
   output logic        iready,
   output logic [31:0] instruction,
   output logic [31:0] mem_addr,
   output logic        mem_ren,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busy,
   output logic        fetch_fault
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   fetch_state_t r_state;
   fetch_state_t w_next_state;
   logic [31:0]  r_addr_q;
   logic [31:0]  r_instruction;
   logic         w_latch;
   logic         w_load;

`ifdef FETCH_TIMEOUT_EN
   logic w_expired;
   logic w_wd_count_en;
   logic w_wd_clear;

   assign w_wd_count_en = (r_state == FETCH) && mem_busy;
   assign w_wd_clear    = !w_wd_count_en;

   fetch_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .nRST     (nRST),
      .count_en (w_wd_count_en),
      .clear    (w_wd_clear),
      .expired  (w_expired)
   );
`endif

   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         IDLE: begin
            if (fetch_en) begin
               if (PCaddr[1:0] == 2'b00) begin
                  w_next_state = FETCH;
                  w_latch      = 1'b1;
               end else begin
                  w_next_state = FAULT;
               end
            end
         end
         FETCH: begin
            // a PC redirect while the bus was busy makes the returned word stale
            if (!mem_busy) begin
               if (PCaddr == r_addr_q) begin
                  w_next_state = DONE;
                  w_load       = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
`ifdef FETCH_TIMEOUT_EN
            else if (w_expired) begin
               w_next_state = FAULT;
            end
`endif
         end
         DONE:    w_next_state = IDLE;
         FAULT:   w_next_state = FAULT;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_state       <= IDLE;
         r_addr_q      <= '0;
         r_instruction <= NOP_INSTR;
      end else begin
         r_state <= w_next_state;
         if (w_latch) begin
            r_addr_q <= PCaddr;
         end
         if (w_load) begin
            r_instruction <= mem_rdata;
         end
      end
   end

   assign iready      = (r_state == DONE);
   assign mem_ren     = (r_state == FETCH);
   assign fetch_fault = (r_state == FAULT);
   assign mem_addr    = r_addr_q;
   assign instruction = r_instruction;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, watchdog limit in cycles of continuous mem_busy (range 1..255).
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- PCaddr  in  32  current program counter from the PC block.
- fetch_en  in  1  core permits new fetches (low = halt).
- iready  out  1  instruction valid, single-cycle pulse; PC advances on it.
- instruction  out  32  last fetched instruction word.
- mem_addr  out  32  instruction memory word address.
- mem_ren  out  1  memory read request.
- mem_rdata  in  32  memory read data, valid when mem_ren=1 and mem_busy=0.
- mem_busy  in  1  memory not ready; request is held while high.
- fetch_fault  out  1  sticky fault flag (misaligned PC or timeout).

Function
REQ-003 SHALL implement states IDLE, FETCH, DONE, FAULT.
REQ-004 IDLE: if fetch_en=1 and PCaddr[1:0]=0, SHALL latch PCaddr into addr_q and go to FETCH; if fetch_en=1 and PCaddr[1:0]!=0, SHALL go to FAULT; if fetch_en=0, SHALL stay in IDLE.
REQ-005 FETCH: SHALL drive mem_ren=1 and mem_addr=addr_q, held stable until mem_busy=0 is sampled.
REQ-006 FETCH with mem_busy=0 and PCaddr==addr_q: SHALL load instruction<=mem_rdata and go to DONE.
REQ-007 FETCH with mem_busy=0 and PCaddr!=addr_q (PC changed mid-fetch): SHALL discard mem_rdata, leave instruction unchanged, and go to IDLE with no iready.
REQ-008 DONE: SHALL assert iready=1 for exactly one cycle, then go to IDLE.
REQ-009 iready SHALL be 0 in every state other than DONE; mem_ren SHALL be 0 outside FETCH; mem_addr SHALL hold addr_q in all states.
REQ-010 Minimum latency with mem_busy=0: latch in IDLE at cycle N, mem_ren in cycle N+1, iready in cycle N+2 (3 cycles per instruction).
REQ-011 fetch_en falling during FETCH SHALL NOT abort the bus transaction; the fetch completes per REQ-006/007.
REQ-012 FAULT: SHALL hold fetch_fault=1, iready=0, mem_ren=0, and exit only on reset.

Reset
REQ-013 On nRST=0, asynchronously and regardless of state (including mid-FETCH): state=IDLE, addr_q=0, mem_addr=0, mem_ren=0, iready=0, instruction=32'h00000013 (NOP), fetch_fault=0, watchdog count=0.
REQ-014 After nRST release, the first fetch SHALL start in the first cycle with fetch_en=1.

Configuration
REQ-015 Macro FETCH_TIMEOUT_EN: when defined, a watchdog SHALL count consecutive FETCH cycles with mem_busy=1, clear on leaving FETCH, and on reaching TIMEOUT_CYCLES go to FAULT with mem_ren dropped the next cycle.
REQ-016 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, FAULT SHALL be reachable only through misalignment, and no watchdog logic SHALL be synthesized.

Structure
REQ-017 Package fetch_pkg SHALL hold the fetch_state_t enum (IDLE, FETCH, DONE, FAULT), the NOP_INSTR constant 32'h00000013, and the default TIMEOUT_CYCLES.
REQ-018 The watchdog SHALL be sub-module fetch_watchdog (inputs clk, nRST, count_en, clear; output expired), instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-019 Reset mid-FETCH with mem_busy=1 -> next cycle mem_ren=0, instruction=32'h00000013, iready=0, fetch_fault=0.
REQ-020 PCaddr=32'h00000100, mem_busy=0, mem_rdata=32'h00A00093 -> mem_ren high 1 cycle with mem_addr=0x100, iready pulses 2 cycles after latch, instruction=32'h00A00093.
REQ-021 mem_busy high 5 cycles, then low -> mem_addr held at 0x100 throughout, single iready pulse 1 cycle after busy drops.
REQ-022 PCaddr changed from 0x100 to 0x200 during FETCH -> no iready, instruction unchanged, new fetch issued with mem_addr=0x200.
REQ-023 PCaddr=32'h00000102 with fetch_en=1 -> fetch_fault=1 next cycle, mem_ren never asserted, flag held until nRST.
REQ-024 With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_busy held high -> FAULT after 4 busy cycles; without the macro, same stimulus keeps mem_ren=1 indefinitely.
